vec_ctrl: RTL
=============

Name: vec_ctrl

Overview:
- Interrupt and vector-fetch controller for the paged 6800-family CPU.
- Latches 8 peripheral IRQ sources and one NMI source, masks them, and drives the CPU irq/nmi pins.
- When the CPU reads a vector at $FFF8-$FFFF, it overrides the data bus with the 24-bit programmed vector from the page/vector register block.
- On the low-byte fetch it issues a one-cycle page load with vector bits [20:16], and saves the interrupted page.

Parameters:
- NSRC, 8, number of IRQ sources; fixed range 1..8. Source 0 has the highest priority.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- bus_en  in  1  one-cycle strobe per CPU bus cycle
- vma  in  1  CPU valid memory address
- cpu_rw  in  1  CPU read (1) / write (0)
- cpu_a  in  16  CPU address
- vec_sel  out  1  combinational; 1 = vec_do replaces CPU read data this cycle
- vec_do  out  8  combinational vector byte
- irq_addr, swi_addr, nmi_addr, res_addr  in  24 each  programmed vectors
- cur_page  in  5  current page
- page_load  out  1  one-cycle pulse: load page_new into page register
- page_new  out  5  page value to load
- irq_src  in  NSRC  peripheral IRQ levels
- nmi_in  in  1  NMI request level
- cpu_irq  out  1  registered, active high
- cpu_nmi  out  1  registered, active high
- AD  in  3  register select
- DI  in  8  write data
- DO  out  8  read data, registered
- rw  in  1  1 = read, 0 = write
- cs  in  1  register select strobe

Behaviour:
- Reset values:
  - cpu_irq, cpu_nmi, page_load, vec_sel = 0; page_new = 0; DO = 0.
  - PEND = 0, MASK = 0, CAUSE = 0, SAVEPG = 0, CTRL.VEN = 1.
  - FSM = IDLE; edge-detect history = 0.
- Registers (cs=1, one clk per access; read data appears in DO on the next clk):
  - 0 PEND: R = pending bits. W = write-1-to-clear.
  - 1 MASK: RW, 1 = enabled.
  - 2 CAUSE: R = {ACT, 4'b0, src[2:0]}. ACT is set on IRQ vector completion and cleared by any write to CAUSE.
  - 3 SAVEPG: R = {3'b0, saved page}.
  - 4 CTRL: RW, bit0 VEN (vector override enable); other bits read 0.
  - 5-7: read 0, writes ignored.
- IRQ latching:
  - A rising edge on irq_src[i] (sampled every clk) sets PEND[i].
  - If a set and a clear of the same bit occur in the same clk, the set wins.
  - cpu_irq <= |(PEND & MASK), one clk latency.
- NMI:
  - A rising edge on nmi_in sets nmi_lat; cpu_nmi <= nmi_lat.
  - nmi_lat clears on NMI vector low-byte fetch; a new edge in that same clk wins.
- Vector FSM (advances only on bus_en & vma):
  - IDLE: on a read at $FFF8/$FFFA/$FFFC/$FFFE with VEN=1:
    - vec_sel=1; vec_do = selected vector [15:8] (IRQ/SWI/NMI/RES respectively).
    - Latch vector id; go to HI.
  - HI, read at latched base+1:
    - vec_sel=1; vec_do = vector [7:0].
    - page_load=1 for that clk; page_new = vector [20:16]; SAVEPG <= cur_page.
    - IRQ: CAUSE <= {1, highest-priority index of PEND & MASK at this clk}; with zero pending, src = 7 and ACT still set.
    - Go to IDLE.
  - HI, any other bus cycle: no override, no page_load, go to IDLE (abort).
  - A read at an odd vector address in IDLE is not overridden.
  - Writes to $FFF8-$FFFF are never overridden.
- VEN=0: vec_sel stays 0, FSM held in IDLE, no page_load; IRQ/NMI latching is unaffected.
- Reset mid-sequence: FSM returns to IDLE and no page_load is issued.
- vector [23:21] are ignored.

Optional Feature:
- VECCTL_AUTOEOI_EN:
  - Defined: the IRQ low-byte fetch also clears PEND[src] for the recorded source (set-wins rule still applies).
  - Undefined: PEND is cleared only by software W1C.

Test Plan:
1. Reset, then read $FFFE then $FFFF (res_addr=0x03C123) -> vec_do 0xC1 then 0x23; page_load pulses with page_new=3 on the second read; SAVEPG = prior cur_page.
2. MASK=0x0C, pulse irq_src[3] then irq_src[2] -> PEND=0x0C, cpu_irq=1 one clk after the first edge; IRQ vector fetch -> CAUSE=0x82; PEND=0x08 with AUTOEOI, 0x0C without.
3. Write PEND=0x04 in the same clk as a rising edge on irq_src[2] -> PEND[2] remains 1.
4. nmi_in edge -> cpu_nmi=1; read $FFFC then $0100 (abort) -> no page_load, cpu_nmi still 1; read $FFFC,$FFFD -> page_load, cpu_nmi=0 two clk later.
5. CTRL=0x00, read $FFF8/$FFF9 -> vec_sel=0, no page_load; cpu_irq still follows PEND & MASK.
6. Assert rst in HI state -> next $FFF9 read not overridden; all registers at reset values.

Source files
------------

// File: rtl/vec_ctrl_if.sv
// CPU bus cycle and register-port signals for vec_ctrl.
interface vec_ctrl_if;
  logic        bus_en;
  logic        vma;
  logic        cpu_rw;
  logic [15:0] cpu_a;
  logic        vec_sel;
  logic [7:0]  vec_do;
  logic [2:0]  AD;
  logic [7:0]  DI;
  logic [7:0]  DO;
  logic        rw;
  logic        cs;

  modport master (
    output bus_en, vma, cpu_rw, cpu_a, AD, DI, rw, cs,
    input  vec_sel, vec_do, DO
  );

  modport slave (
    input  bus_en, vma, cpu_rw, cpu_a, AD, DI, rw, cs,
    output vec_sel, vec_do, DO
  );
endinterface

// File: rtl/vec_ctrl.sv
// Interrupt latch/mask and 24-bit vector-fetch override for a paged 6800 CPU.
// Optional macro VECCTL_AUTOEOI_EN: IRQ low-byte vector fetch also clears PEND[src].
module vec_ctrl #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  vec_ctrl_if.slave       bus,
  input  logic [23:0]     irq_addr,
  input  logic [23:0]     swi_addr,
  input  logic [23:0]     nmi_addr,
  input  logic [23:0]     res_addr,
  input  logic [4:0]      cur_page,
  output logic            page_load,
  output logic [4:0]      page_new,
  input  logic [NSRC-1:0] irq_src,
  input  logic            nmi_in,
  output logic            cpu_irq,
  output logic            cpu_nmi
);

  typedef enum logic {IDLE, HI} state_t;
  typedef enum logic [1:0] {V_IRQ, V_SWI, V_NMI, V_RES} vid_t;

  state_t state, state_nxt;
  vid_t   vid, vid_nxt, sel_id;

  logic [NSRC-1:0] pend, mask, irq_q, rise, act, w1c, eoi_clr;
  logic            nmi_q, nmi_lat, ven;
  logic            cause_act;
  logic [2:0]      cause_src, src;
  logic [4:0]      savepg;
  logic            any, found;
  logic            bus_cyc, rd_cyc, vec_hi_hit, lo_fetch, irq_done, nmi_clr;
  logic            wr, rd;
  logic [23:0]     vec_vec;
  logic [7:0]      pend8, mask8, rdata;
  logic            unused_bits;

  assign bus_cyc    = bus.bus_en & bus.vma;
  assign rd_cyc     = bus_cyc & bus.cpu_rw;
  assign vec_hi_hit = rd_cyc & (bus.cpu_a[15:3] == 13'h1FFF) & ~bus.cpu_a[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vid   <= V_IRQ;
    end else begin
      state <= state_nxt;
      vid   <= vid_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    vid_nxt     = vid;
    sel_id      = vid;
    bus.vec_sel = 1'b0;
    lo_fetch    = 1'b0;
    case (state)
      IDLE: begin
        if (ven && vec_hi_hit) begin
          bus.vec_sel = 1'b1;
          sel_id      = vid_t'(bus.cpu_a[2:1]);
          vid_nxt     = vid_t'(bus.cpu_a[2:1]);
          state_nxt   = HI;
        end
      end
      HI: begin
        if (!ven) begin
          state_nxt = IDLE;
        end else if (bus_cyc) begin
          state_nxt = IDLE;
          if (rd_cyc && bus.cpu_a == {13'h1FFF, vid, 1'b1}) begin
            bus.vec_sel = 1'b1;
            lo_fetch    = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Suppress the override and page load in a reset cycle so a sequence cut by rst has no effect.
    if (rst) begin
      bus.vec_sel = 1'b0;
      lo_fetch    = 1'b0;
    end
  end

  always_comb begin
    case (sel_id)
      V_IRQ:   vec_vec = irq_addr;
      V_SWI:   vec_vec = swi_addr;
      V_NMI:   vec_vec = nmi_addr;
      default: vec_vec = res_addr;
    endcase
  end

  assign bus.vec_do  = !bus.vec_sel ? 8'h00 : (state == HI ? vec_vec[7:0] : vec_vec[15:8]);
  assign page_load   = lo_fetch;
  assign page_new    = lo_fetch ? vec_vec[20:16] : 5'd0;
  assign unused_bits = ^vec_vec[23:21];

  assign irq_done = lo_fetch & (vid == V_IRQ);
  assign nmi_clr  = lo_fetch & (vid == V_NMI);
  assign rise     = irq_src & ~irq_q;
  assign act      = pend & mask;
  assign any      = |act;

  always_comb begin
    src   = 3'd7;
    found = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (act[i] && !found) begin
        src   = 3'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    eoi_clr = '0;
`ifdef VECCTL_AUTOEOI_EN
    if (irq_done && any) eoi_clr[src] = 1'b1;
`else
    eoi_clr = '0;
`endif
  end

  assign wr  = bus.cs & ~bus.rw;
  assign rd  = bus.cs & bus.rw;
  assign w1c = (wr && bus.AD == 3'd0) ? bus.DI[NSRC-1:0] : '0;

  always_comb begin
    pend8             = '0;
    mask8             = '0;
    pend8[NSRC-1:0]   = pend;
    mask8[NSRC-1:0]   = mask;
    case (bus.AD)
      3'd0:    rdata = pend8;
      3'd1:    rdata = mask8;
      3'd2:    rdata = {cause_act, 4'b0000, cause_src};
      3'd3:    rdata = {3'b000, savepg};
      3'd4:    rdata = {7'd0, ven};
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q     <= '0;
      nmi_q     <= 1'b0;
      pend      <= '0;
      mask      <= '0;
      nmi_lat   <= 1'b0;
      cpu_irq   <= 1'b0;
      cpu_nmi   <= 1'b0;
      cause_act <= 1'b0;
      cause_src <= 3'd0;
      savepg    <= 5'd0;
      ven       <= 1'b1;
      bus.DO    <= 8'h00;
    end else begin
      irq_q   <= irq_src;
      nmi_q   <= nmi_in;
      // Clears first, then edges OR in, so a same-cycle set wins.
      pend    <= (pend & ~(w1c | eoi_clr)) | rise;
      nmi_lat <= (nmi_lat & ~nmi_clr) | (nmi_in & ~nmi_q);
      cpu_irq <= any;
      cpu_nmi <= nmi_lat;
      if (wr) begin
        case (bus.AD)
          3'd1:    mask      <= bus.DI[NSRC-1:0];
          3'd2:    cause_act <= 1'b0;
          3'd4:    ven       <= bus.DI[0];
          default: ;
        endcase
      end
      if (lo_fetch) savepg <= cur_page;
      if (irq_done) begin
        cause_act <= 1'b1;
        cause_src <= src;
      end
      if (rd) bus.DO <= rdata;
    end
  end

endmodule
